// File: rtl/pz_stream_downsizer.sv
// pz_stream_downsizer: wide-to-narrow stream width converter.
// Splits each wide beat into OUT_WIDTH slices, lowest slice first, and
// emits only slices that carry at least one enabled byte.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   wide beat handshake (i_data, i_byte_enable, i_last)
//   o_valid / i_ready   narrow beat handshake (o_data, o_byte_enable, o_last)
//
// A held beat retires on the accept of its final non-empty slice, and a
// new wide beat may load on that same edge, so back-to-back packets flow
// at one narrow beat per cycle. A wide beat with no enabled bytes is
// dropped unless it closes a packet; then it becomes one narrow beat with
// zero byte enables so that the packet boundary still reaches the sink.

module pz_stream_downsizer #(
    parameter int OUT_WIDTH = 32,
    parameter int RATIO     = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [OUT_WIDTH*RATIO-1:0]    i_data,
    input  logic [OUT_WIDTH*RATIO/8-1:0]  i_byte_enable,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic [OUT_WIDTH/8-1:0]        o_byte_enable,
    output logic                          o_last
);

    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int OBW      = OUT_WIDTH / 8;
    localparam int IBW      = IN_WIDTH / 8;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [IN_WIDTH-1:0] hold_data;
    logic [IBW-1:0]      hold_be;
    logic                hold_last;
    logic                buf_valid;
    logic [IDX_W-1:0]    idx;

    logic [RATIO-1:0]    hold_ne;
    logic [RATIO-1:0]    in_ne;
    logic [IDX_W-1:0]    in_first;
    logic [IDX_W-1:0]    idx_next;
    logic                has_next;
    logic                final_slice;
    logic                in_empty;
    logic                wide_acc;
    logic                narrow_acc;
    logic                load;

    // Per-slice "any byte enabled" flags for the held and incoming beats.
    always_comb begin
        hold_ne = '0;
        in_ne   = '0;
        for (int k = 0; k < RATIO; k++) begin
            hold_ne[k] = |hold_be[k*OBW +: OBW];
            in_ne[k]   = |i_byte_enable[k*OBW +: OBW];
        end
    end

    // Lowest non-empty slice of the incoming beat; 0 when it is empty.
    always_comb begin
        in_first = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (in_ne[k]) begin
                in_first = IDX_W'(k);
            end
        end
    end

    // Lowest non-empty held slice strictly above the current index.
    always_comb begin
        idx_next = idx;
        has_next = 1'b0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (hold_ne[k] && (k > int'(idx))) begin
                idx_next = IDX_W'(k);
                has_next = 1'b1;
            end
        end
    end

    // An empty-last beat has nothing above idx 0, so it is final too.
    assign final_slice = !has_next;
    assign in_empty    = ~|in_ne;

    assign o_ready    = !i_rst && (!buf_valid || (i_ready && final_slice));
    assign wide_acc   = i_valid && o_ready;
    assign narrow_acc = buf_valid && i_ready;

    // Empty beats that do not close a packet are swallowed here.
    assign load = wide_acc && (!in_empty || i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_data <= '0;
            hold_be   <= '0;
            hold_last <= 1'b0;
            buf_valid <= 1'b0;
            idx       <= '0;
        end else if (load) begin
            hold_data <= i_data;
            hold_be   <= i_byte_enable;
            hold_last <= i_last;
            buf_valid <= 1'b1;
            idx       <= in_first;
        end else if (narrow_acc) begin
            if (final_slice) begin
                buf_valid <= 1'b0;
            end else begin
                idx <= idx_next;
            end
        end
    end

    // Output slice mux; disabled bytes pass the held data through unchanged.
    always_comb begin
        o_data        = '0;
        o_byte_enable = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                o_data        = hold_data[k*OUT_WIDTH +: OUT_WIDTH];
                o_byte_enable = hold_be[k*OBW +: OBW];
            end
        end
    end

    assign o_valid = buf_valid;
    assign o_last  = hold_last && final_slice;

endmodule
